// File: rtl/axi_txn_sequencer_pkg.sv
// Shared types and helpers for the AXI transaction sequencer.
package axi_txn_sequencer_pkg;

  localparam int unsigned SEQ_CNT_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    StIdle,
    StPulse,
    StWaitClr,
    StWaitDone,
    StGap,
    StFinish
  } seq_state_t;

  // Increment a count of the given width, holding at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/axi_txn_seq_pulse_gen.sv
// Loadable down-counter timing both the INIT pulse width and the inter-run gap.
module axi_txn_seq_pulse_gen #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] len_i,
  output logic             active_o,
  output logic             expire_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = len_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign active_o = (cnt_q != '0);
  // Last cycle of the loaded interval.
  assign expire_o = (cnt_q == Width'(1));

endmodule

// File: rtl/axi_txn_sequencer.sv
// Drives repeated INIT pulses into the AXI master and tallies run/error counts.
// Optional per-run watchdog enabled by defining SEQ_TIMEOUT_EN.
module axi_txn_sequencer
  import axi_txn_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W             = SEQ_CNT_W_DEFAULT,
  parameter int unsigned INIT_PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES        = 8,
  parameter int unsigned TIMEOUT_CYCLES    = 65535
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             START,
  input  logic [CNT_W-1:0] NUM_RUNS,
  output logic             M_AXI_INIT_AXI_TXN,
  input  logic             M_AXI_TXN_DONE,
  input  logic             M_AXI_ERROR,
  output logic             BUSY,
  output logic             SEQ_DONE,
  output logic             PASS,
  output logic [CNT_W-1:0] RUN_CNT,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic             TIMEOUT
);

  localparam int unsigned PulseW = 8;
  localparam logic [PulseW-1:0] PulseLen = PulseW'(INIT_PULSE_CYCLES);
  localparam logic [PulseW-1:0] GapLen   = PulseW'(GAP_CYCLES);

  seq_state_t       state_q, state_d;
  logic             done_q, init_q, init_d;
  logic             busy_q, busy_d, seq_done_q, seq_done_d, pass_q, pass_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d, err_cnt_q, err_cnt_d, num_runs_q, num_runs_d;
  logic             rise, abort, run_end, run_err;
  logic             pg_load, pg_active, pg_expire;
  logic [PulseW-1:0] pg_len;

  assign rise = M_AXI_TXN_DONE & ~done_q;

  axi_txn_seq_pulse_gen #(
    .Width (PulseW)
  ) u_pulse_gen (
    .clk_i    (ACLK),
    .rst_ni   (ARESETN),
    .load_i   (pg_load),
    .len_i    (pg_len),
    .active_o (pg_active),
    .expire_o (pg_expire)
  );

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    seq_done_d = seq_done_q;
    pass_d     = pass_q;
    run_cnt_d  = run_cnt_q;
    err_cnt_d  = err_cnt_q;
    num_runs_d = num_runs_q;
    pg_load    = 1'b0;
    pg_len     = '0;
    run_end    = 1'b0;
    run_err    = 1'b0;

    unique case (state_q)
      StIdle, StFinish: begin
        if (START) begin
          num_runs_d = NUM_RUNS;
          run_cnt_d  = '0;
          err_cnt_d  = '0;
          seq_done_d = 1'b0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
          if (NUM_RUNS == '0) begin
            state_d    = StFinish;
            busy_d     = 1'b0;
            seq_done_d = 1'b1;
            pass_d     = 1'b1;
          end else begin
            state_d = StPulse;
            pg_load = 1'b1;
            pg_len  = PulseLen;
          end
        end
      end
      StPulse: begin
        if (pg_expire) state_d = StWaitClr;
      end
      // The master drops TXN_DONE on the init edge; wait for that before arming rise.
      StWaitClr: begin
        if (!M_AXI_TXN_DONE) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (rise) begin
          run_end = 1'b1;
          run_err = M_AXI_ERROR;
        end
      end
      StGap: begin
        if (pg_expire && pg_active) begin
          state_d = StPulse;
          pg_load = 1'b1;
          pg_len  = PulseLen;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      run_end = 1'b1;
      run_err = 1'b1;
    end

    if (run_end) begin
      run_cnt_d = CNT_W'(sat_inc(32'(run_cnt_q), CNT_W));
      if (run_err) err_cnt_d = CNT_W'(sat_inc(32'(err_cnt_q), CNT_W));
      if (abort || (run_cnt_d == num_runs_q)) begin
        state_d    = StFinish;
        busy_d     = 1'b0;
        seq_done_d = 1'b1;
        pass_d     = (err_cnt_d == '0) && !abort;
      end else if (GAP_CYCLES == 0) begin
        state_d = StPulse;
        pg_load = 1'b1;
        pg_len  = PulseLen;
      end else begin
        state_d = StGap;
        pg_load = 1'b1;
        pg_len  = GapLen;
      end
    end

    init_d = (state_d == StPulse);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= StIdle;
      done_q     <= 1'b0;
      init_q     <= 1'b0;
      busy_q     <= 1'b0;
      seq_done_q <= 1'b0;
      pass_q     <= 1'b0;
      run_cnt_q  <= '0;
      err_cnt_q  <= '0;
      num_runs_q <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= M_AXI_TXN_DONE;
      init_q     <= init_d;
      busy_q     <= busy_d;
      seq_done_q <= seq_done_d;
      pass_q     <= pass_d;
      run_cnt_q  <= run_cnt_d;
      err_cnt_q  <= err_cnt_d;
      num_runs_q <= num_runs_d;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           timeout_q, timeout_d, waiting, start_acc;

  assign waiting   = (state_q == StWaitClr) || (state_q == StWaitDone);
  assign start_acc = START && ((state_q == StIdle) || (state_q == StFinish));
  // A genuine completion on the limit cycle takes precedence over the watchdog.
  assign abort     = waiting && (wd_q == WdW'(TIMEOUT_CYCLES - 1)) &&
                     !((state_q == StWaitDone) && rise);

  always_comb begin
    wd_d      = waiting ? wd_q + 1'b1 : '0;
    timeout_d = timeout_q;
    if (abort) wd_d = '0;
    if (start_acc) begin
      timeout_d = 1'b0;
    end else if (abort) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign TIMEOUT = timeout_q;
`else
  assign abort   = 1'b0;
  assign TIMEOUT = 1'b0;
`endif

  assign M_AXI_INIT_AXI_TXN = init_q;
  assign BUSY               = busy_q;
  assign SEQ_DONE           = seq_done_q;
  assign PASS               = pass_q;
  assign RUN_CNT            = run_cnt_q;
  assign ERR_CNT            = err_cnt_q;

endmodule

// File: tb/tb_axi_txn_sequencer.sv
// Self-checking bench for axi_txn_sequencer with a behavioural AXI master model.
module tb_axi_txn_sequencer;

  localparam int INIT_P = 2;
  localparam int GAP_P  = 8;
  localparam int TO_P   = 100;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        START = 1'b0;
  logic [15:0] NUM_RUNS = '0;
  logic        INIT, DONE, ERROR;
  logic        BUSY, SEQ_DONE, PASS, TIMEOUT;
  logic [15:0] RUN_CNT, ERR_CNT;

  // Master model state (negedge-driven), plus manual override for corner cases.
  bit          master_en = 1'b1;
  logic        m_done = 1'b0, m_err = 1'b0, man_done = 1'b0, man_err = 1'b0;
  int          cfg_lat = 50;
  logic [15:0] cfg_mask = '0;
  int          pulses = 0, cyc = 0, done_t = 0, cur_w = 0, countdown = 0, run_idx = 0;
  bit          have_done = 0, init_prev = 0;
  int          widths[$];
  int          gaps[$];

  int checks = 0;
  int errors = 0;

  assign DONE  = master_en ? m_done : man_done;
  assign ERROR = master_en ? m_err : man_err;

  axi_txn_sequencer #(
    .CNT_W             (16),
    .INIT_PULSE_CYCLES (INIT_P),
    .GAP_CYCLES        (GAP_P),
    .TIMEOUT_CYCLES    (TO_P)
  ) dut (
    .ACLK               (ACLK),
    .ARESETN            (ARESETN),
    .START              (START),
    .NUM_RUNS           (NUM_RUNS),
    .M_AXI_INIT_AXI_TXN (INIT),
    .M_AXI_TXN_DONE     (DONE),
    .M_AXI_ERROR        (ERROR),
    .BUSY               (BUSY),
    .SEQ_DONE           (SEQ_DONE),
    .PASS               (PASS),
    .RUN_CNT            (RUN_CNT),
    .ERR_CNT            (ERR_CNT),
    .TIMEOUT            (TIMEOUT)
  );

  always #5 ACLK = ~ACLK;

  // Master: clears done on the init edge, raises it cfg_lat cycles later with the run's error bit.
  always @(negedge ACLK) begin
    cyc++;
    if (!ARESETN) begin
      m_done = 1'b0; m_err = 1'b0; countdown = 0; init_prev = 0; have_done = 0; run_idx = 0;
    end else begin
      if (!BUSY) run_idx = 0;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          m_done = 1'b1;
          m_err = cfg_mask[run_idx[3:0]];
          run_idx++;
          have_done = 1;
          done_t = cyc;
        end
      end
      if (INIT && !init_prev) begin
        pulses++;
        cur_w = 1;
        m_done = 1'b0;
        m_err = 1'b0;
        countdown = cfg_lat;
        if (have_done) gaps.push_back(cyc - done_t);
      end else if (INIT) begin
        cur_w++;
      end else if (init_prev) begin
        widths.push_back(cur_w);
      end
      if (SEQ_DONE) have_done = 0;
      init_prev = INIT;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_pulse(input int n);
    @(negedge ACLK);
    START = 1'b1;
    NUM_RUNS = 16'(n);
    @(negedge ACLK);
    START = 1'b0;
  endtask

  task automatic run_seq(input string tag, input int n, input logic [15:0] mask, input int lat,
                         input int exp_run, input int exp_err, input bit exp_pass, input bit poke);
    int p0, w0, g0, budget, wmin, wmax, gmin, gmax;
    bit seen;
    cfg_lat = lat;
    cfg_mask = mask;
    p0 = pulses; w0 = widths.size(); g0 = gaps.size();
    start_pulse(n);
    check($sformatf("%s.busy", tag), BUSY, 1);
    budget = n * (lat + GAP_P + INIT_P + 10) + 50;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (SEQ_DONE) begin
        seen = 1;
        break;
      end
      // A START while busy must be ignored.
      if (poke && i == 20) begin
        START = 1'b1;
        NUM_RUNS = 16'd1;
      end else if (poke && i == 21) begin
        START = 1'b0;
      end
      @(negedge ACLK);
    end
    START = 1'b0;
    check($sformatf("%s.finished", tag), seen, 1);
    check($sformatf("%s.run_cnt", tag), RUN_CNT, exp_run);
    check($sformatf("%s.err_cnt", tag), ERR_CNT, exp_err);
    check($sformatf("%s.pass", tag), PASS, exp_pass);
    check($sformatf("%s.busy_end", tag), BUSY, 0);
    check($sformatf("%s.pulses", tag), pulses - p0, exp_run);
    wmin = 999; wmax = 0;
    for (int k = w0; k < widths.size(); k++) begin
      if (widths[k] < wmin) wmin = widths[k];
      if (widths[k] > wmax) wmax = widths[k];
    end
    check($sformatf("%s.width_min", tag), wmin, INIT_P);
    check($sformatf("%s.width_max", tag), wmax, INIT_P);
    if (n >= 2) begin
      gmin = 999; gmax = 0;
      for (int k = g0; k < gaps.size(); k++) begin
        if (gaps[k] < gmin) gmin = gaps[k];
        if (gaps[k] > gmax) gmax = gaps[k];
      end
      // Completion cycle plus GAP_P idle cycles before the next init goes high.
      check($sformatf("%s.gap_min", tag), gmin, GAP_P + 1);
      check($sformatf("%s.gap_max", tag), gmax, GAP_P + 1);
    end
  endtask

  typedef struct {
    int          n;
    logic [15:0] mask;
    int          lat;
    int          exp_run;
    int          exp_err;
    bit          exp_pass;
    bit          poke;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #3000000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n, e, lat, k;
    logic [15:0] mask;
    bit seen;

    vecs[0] = '{n: 3, mask: 16'h0000, lat: 50, exp_run: 3, exp_err: 0, exp_pass: 1, poke: 1};
    vecs[1] = '{n: 4, mask: 16'h0002, lat: 50, exp_run: 4, exp_err: 1, exp_pass: 0, poke: 0};
    vecs[2] = '{n: 1, mask: 16'h0001, lat: 10, exp_run: 1, exp_err: 1, exp_pass: 0, poke: 0};
    vecs[3] = '{n: 5, mask: 16'h0015, lat: 12, exp_run: 5, exp_err: 3, exp_pass: 0, poke: 0};
    vecs[4] = '{n: 2, mask: 16'h0000, lat: 4,  exp_run: 2, exp_err: 0, exp_pass: 1, poke: 0};

    ARESETN = 1'b1;
    #2 ARESETN = 1'b0;
    @(negedge ACLK);
    check("rst.init", INIT, 0);
    check("rst.busy", BUSY, 0);
    check("rst.seq_done", SEQ_DONE, 0);
    check("rst.pass", PASS, 0);
    check("rst.run_cnt", RUN_CNT, 0);
    check("rst.err_cnt", ERR_CNT, 0);
    check("rst.timeout", TIMEOUT, 0);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);

    foreach (vecs[i]) begin
      run_seq($sformatf("vec%0d", i), vecs[i].n, vecs[i].mask, vecs[i].lat,
              vecs[i].exp_run, vecs[i].exp_err, vecs[i].exp_pass, vecs[i].poke);
    end

    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 6);
      mask = 16'($urandom);
      lat = $urandom_range(4, 30);
      e = 0;
      for (int r = 0; r < n; r++) if (mask[r]) e++;
      run_seq($sformatf("rnd%0d", it), n, mask, lat, n, e, (e == 0), 0);
    end

    // Zero runs: straight to done, no init pulse.
    k = pulses;
    start_pulse(0);
    @(negedge ACLK);
    check("zero.seq_done", SEQ_DONE, 1);
    check("zero.pass", PASS, 1);
    check("zero.run_cnt", RUN_CNT, 0);
    repeat (5) @(negedge ACLK);
    check("zero.pulses", pulses - k, 0);

    // Stale TXN_DONE high from a previous run must not count.
    master_en = 1'b0;
    man_done = 1'b1;
    man_err = 1'b1;
    repeat (3) @(negedge ACLK);
    start_pulse(1);
    repeat (10) @(negedge ACLK);
    check("stale.run_cnt_held", RUN_CNT, 0);
    check("stale.busy", BUSY, 1);
    man_done = 1'b0;
    man_err = 1'b0;
    repeat (3) @(negedge ACLK);
    check("stale.run_cnt_low", RUN_CNT, 0);
    check("stale.seq_done_low", SEQ_DONE, 0);
    man_done = 1'b1;
    repeat (3) @(negedge ACLK);
    check("stale.seq_done", SEQ_DONE, 1);
    check("stale.run_cnt", RUN_CNT, 1);
    check("stale.err_cnt", ERR_CNT, 0);
    check("stale.pass", PASS, 1);
    master_en = 1'b1;

    // Reset during run 2 of 5, then a clean re-run.
    cfg_lat = 30;
    cfg_mask = '0;
    start_pulse(5);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (RUN_CNT == 16'd1) begin
        seen = 1;
        break;
      end
      @(negedge ACLK);
    end
    check("midrst.reached_run2", seen, 1);
    repeat (20) @(negedge ACLK);
    check("midrst.busy_before", BUSY, 1);
    ARESETN = 1'b0;
    #1;
    check("midrst.init", INIT, 0);
    check("midrst.busy", BUSY, 0);
    check("midrst.run_cnt", RUN_CNT, 0);
    check("midrst.err_cnt", ERR_CNT, 0);
    check("midrst.seq_done", SEQ_DONE, 0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
    run_seq("rerun", 5, 16'h0000, 30, 5, 0, 1, 0);

`ifdef SEQ_TIMEOUT_EN
    // Master never completes: watchdog aborts after TO_P waiting cycles.
    master_en = 1'b0;
    man_done = 1'b0;
    start_pulse(2);
    k = 1;
    while (!SEQ_DONE && k < 400) begin
      @(negedge ACLK);
      k++;
    end
    check("to.latency", k, INIT_P + TO_P + 1);
    check("to.timeout", TIMEOUT, 1);
    check("to.run_cnt", RUN_CNT, 1);
    check("to.err_cnt", ERR_CNT, 1);
    check("to.pass", PASS, 0);
    check("to.seq_done", SEQ_DONE, 1);
    master_en = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_txn_sequencer.md
Name: axi_txn_sequencer

Overview:
Sequences repeated test runs of the AXI read/write master IP in the block design. Issues INIT pulses to the master and detects TXN_DONE completion. Samples the master's ERROR flag once per run and accumulates pass/fail statistics over a programmed number of runs. Sits between the testbench/PS control and the master's M_AXI_INIT_AXI_TXN / M_AXI_TXN_DONE / M_AXI_ERROR pins, replacing the hand-driven init pulse.

Parameters:
CNT_W, 16, width of run-count and error-count fields
INIT_PULSE_CYCLES, 2, cycles M_AXI_INIT_AXI_TXN held high per run (1..15)
GAP_CYCLES, 8, idle cycles between a run completing and the next INIT pulse (0..255)
TIMEOUT_CYCLES, 65535, watchdog limit per run (only with SEQ_TIMEOUT_EN)

Ports:
ACLK  in  1  clock, all logic rising-edge
ARESETN  in  1  asynchronous active-low reset
START  in  1  single-cycle start request; honoured only in IDLE or FINISH
NUM_RUNS  in  CNT_W  number of runs; sampled on accepted START
M_AXI_INIT_AXI_TXN  out  1  init pulse to AXI master
M_AXI_TXN_DONE  in  1  master completion level
M_AXI_ERROR  in  1  master compare-error flag, valid when TXN_DONE rises
BUSY  out  1  high from accepted START until FINISH entered
SEQ_DONE  out  1  high in FINISH until next accepted START
PASS  out  1  valid when SEQ_DONE: ERR_CNT==0 and no timeout
RUN_CNT  out  CNT_W  completed runs in current sequence
ERR_CNT  out  CNT_W  runs completed with M_AXI_ERROR=1
TIMEOUT  out  1  sticky watchdog flag (tied 0 without SEQ_TIMEOUT_EN)

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; counters 0; done edge-detect register 0.
- Done detection: register M_AXI_TXN_DONE into done_q. rise = TXN_DONE & ~done_q. M_AXI_ERROR is sampled in the same cycle as rise.
- FSM states: IDLE, PULSE, WAIT_CLR, WAIT_DONE, GAP, FINISH.
- IDLE/FINISH + START: latch NUM_RUNS. Clear RUN_CNT, ERR_CNT, TIMEOUT, SEQ_DONE. Set BUSY.
  - If NUM_RUNS==0: go to FINISH next cycle with PASS=1.
  - Otherwise go to PULSE.
- PULSE: M_AXI_INIT_AXI_TXN=1 for exactly INIT_PULSE_CYCLES cycles, registered output. First high cycle is the cycle after START. Then go to WAIT_CLR.
- WAIT_CLR: wait for TXN_DONE==0, since the master clears done on the init edge. Then go to WAIT_DONE.
  - If TXN_DONE is already 0 on entry, leave after 1 cycle.
- WAIT_DONE: on rise, RUN_CNT+1 and ERR_CNT+M_AXI_ERROR (both saturate at all-ones).
  - If RUN_CNT+1 == latched NUM_RUNS: go to FINISH.
  - Else: go to GAP.
- GAP: count GAP_CYCLES cycles, then go to PULSE. With GAP_CYCLES=0, go to PULSE directly.
- FINISH: BUSY=0, SEQ_DONE=1, PASS=(ERR_CNT==0)&~TIMEOUT. These are set on the FINISH-entry edge and include the final run's increment.
- START outside IDLE/FINISH is ignored; there is no queueing.
- Reset mid-run: M_AXI_INIT_AXI_TXN drops immediately (async). The sequence is lost.
- TXN_DONE rising outside WAIT_DONE is ignored for counting.

Optional Feature:
Macro SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in WAIT_CLR and WAIT_DONE and is cleared on entry to PULSE.
  - When it reaches TIMEOUT_CYCLES: TIMEOUT=1 (sticky), the run counts as errored (RUN_CNT+1, ERR_CNT+1), and the FSM goes to FINISH (abort), PASS=0.
- Not defined: no watchdog logic; TIMEOUT tied 0; WAIT_DONE can wait forever.

Decomposition:
- Package axi_txn_sequencer_pkg holds:
  - the state enum typedef seq_state_t;
  - constant SEQ_CNT_W_DEFAULT=16;
  - a saturating-increment function sat_inc.
- One natural sub-module, axi_txn_seq_pulse_gen: a loadable down-counter producing the INIT pulse and GAP delay. It has load/len/active/expire ports and is instantiated once, reused by both states.

Test Plan:
- NUM_RUNS=3, master model returns TXN_DONE 50 cycles after init, ERROR=0 -> 3 INIT pulses each 2 cycles wide, separated by ≥8 idle cycles; SEQ_DONE=1, RUN_CNT=3, ERR_CNT=0, PASS=1.
- NUM_RUNS=4, ERROR=1 on run 2 only -> RUN_CNT=4, ERR_CNT=1, PASS=0.
- NUM_RUNS=0 + START -> no INIT pulse; SEQ_DONE=1 two cycles after START, PASS=1, RUN_CNT=0.
- TXN_DONE held high from prior run when START issued -> FSM waits in WAIT_CLR until TXN_DONE low; the stale high is not counted; RUN_CNT increments only on the fresh rise.
- ARESETN asserted during WAIT_DONE of run 2 of 5 -> all outputs 0 asynchronously; after release, a fresh START runs 5 runs from RUN_CNT=0.
- SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, master never asserts done -> TIMEOUT=1 at cycle 100 of waiting, ERR_CNT=1, PASS=0, SEQ_DONE=1.
